ik_iter_ctrl: RTL
=================

Name: ik_iter_ctrl

Overview:
- Parametrised multi-iteration sequencer for the damped-least-squares IK engine.
- Repeatedly enables the single-iteration core and sums its joint deltas into the joint state, scaled, wrapped and clamped.
- Stops on convergence (L1 error norm ≤ tolerance), iteration limit, or abort.
- Sits between the host register interface and the per-iteration core; replaces host-driven single-shot stepping.

Parameters:
- JOINTS, 6, number of joints / delta elements.
- W, 21, signed fixed-point word width.
- FRAC, 16, fraction bits (1.0 = 65536).
- ERR_N, 6, error-vector elements (xyz position + ijk axis).
- MAX_ITER, 255, upper bound for runtime max_iter; ITER_W = $clog2(MAX_ITER+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin run; sampled in IDLE/DONE, ignored otherwise.
- abort  in  1  terminate run.
- max_iter  in  ITER_W  iteration limit (0 treated as 1).
- tol  in  W+3  unsigned L1 error tolerance.
- step_shift  in  3  arithmetic right shift applied to each delta.
- joint_type  in  JOINTS  1 = rotational, 0 = translational.
- dh_init  in  JOINTS×W  initial joint values.
- lim_lo, lim_hi  in  JOINTS×W  per-joint signed limits (lo ≤ hi).
- core_en  out  1  enable to iteration core.
- core_done  in  1  core iteration complete (level, held while core_en high).
- core_delta  in  JOINTS×W  signed joint deltas, valid with core_done.
- core_err  in  ERR_N×W  signed target-minus-actual error, valid with core_done.
- theta  out  JOINTS×W  current joint state; also drives the core's dh_dyn_in.
- busy  out  1  run in progress.
- done  out  1  run finished; level.
- converged  out  1  done by tolerance.
- aborted  out  1  done by abort.
- iter_count  out  ITER_W  completed core iterations.
- err_norm  out  W+3  last L1 error norm.

Behaviour:
Reset
- While rst low, all outputs are 0 and the FSM is in IDLE.
- Asynchronous assert; synchronous-safe deassert.
- Reset mid-run discards all state.

FSM: IDLE, LOAD, RUN, CHECK, UPDATE, DONE.
- IDLE/DONE + start:
  - theta ← dh_init.
  - iter_count, err_norm, done, converged, aborted ← 0.
  - busy ← 1; go to LOAD.
- LOAD: one cycle, core_en = 0; go to RUN.
- RUN:
  - core_en = 1.
  - On core_done: latch core_delta and core_err, iter_count += 1, go to CHECK. core_en drops the next cycle.
- CHECK:
  - err_norm ← Σ|core_err[k]|, each |x| computed at W+1 bits.
  - If err_norm ≤ tol: converged ← 1, go to DONE. The latched delta is not applied.
  - Else go to UPDATE.
- UPDATE, per joint j:
  - s = core_delta[j] >>> step_shift, sign-extended.
  - t = theta[j] + s at W+2 bits.
  - Rotational joints: if t > PI, t −= 2PI; if t < −PI, t += 2PI. At FRAC 16, PI = 205887 and 2PI = 411775.
  - Then clamp t to [lim_lo[j], lim_hi[j]] and store to theta[j].
  - If iter_count ≥ max(max_iter, 1), go to DONE (converged = 0); else go to LOAD.
- DONE: done = 1, busy = 0; hold all outputs until start.

Core handshake
- core_en is low for ≥ 2 cycles between iterations (CHECK, UPDATE, LOAD), so the core clears its done.
- core_done is ignored while core_en is low.

Abort
- In LOAD/RUN/CHECK/UPDATE, abort has priority over every other transition.
- Next state DONE; aborted ← 1, converged ← 0.
- theta keeps its last committed value; no partial UPDATE is applied.
- In IDLE/DONE, abort is ignored.

Other rules
- start and abort in the same cycle while busy: abort wins. In IDLE: start wins.
- iter_count saturates at MAX_ITER.

Decomposition:
- Package ik_pkg:
  - FRAC, PI_FX, TWO_PI_FX constants.
  - typedef fx_t (signed W), fx_vec_t (JOINTS×fx_t), err_vec_t.
  - FSM state enum.
- Sub-module ik_joint_update: combinational shift, wrap and clamp for one joint; instantiated JOINTS times via generate.

Test Plan:
- Immediate convergence: dh_init = 0, core returns core_err all 0, tol = 0 → done = 1, converged = 1, iter_count = 1, theta = 0, err_norm = 0.
- Iteration limit: core_err elements all 65536 (err_norm 393216), tol = 1000, core_delta[0] = 6554, step_shift = 1, max_iter = 3 → theta[0] = 9831, iter_count = 3, converged = 0.
- Clamp: translational joint 1, dh_init = 60000, lim_hi = 65536, delta 20000, step_shift = 0 → theta[1] = 65536. A delta of −200000 with lim_lo = −65536 → −65536.
- Rotational wrap: dh_init = 200000, delta 10000, limits ±205887 → theta = −201775.
- Abort during RUN after 1 completed iteration → core_en low next cycle, done = 1, aborted = 1, converged = 0, theta = post-iteration-1 value.
- Async reset asserted mid-RUN → all outputs 0 in the same cycle; a start after release runs normally with iter_count starting from 0.

Source files
------------

// File: rtl/ik_pkg.sv
// Shared definitions for the damped-least-squares IK iteration sequencer.
//   - Q-format constants for the default 16-bit fraction (PI, 2PI).
//   - Default geometry (joint count, word width, error-vector length).
//   - Fixed-point scalar / vector types at the default geometry.
//   - Sequencer FSM state encoding.
package ik_pkg;

    localparam int JOINTS_DEF   = 6;
    localparam int W_DEF        = 21;
    localparam int ERR_N_DEF    = 6;
    localparam int MAX_ITER_DEF = 255;

    // 1.0 = 2**FRAC
    localparam int FRAC      = 16;
    localparam int PI_FX     = 205887;
    localparam int TWO_PI_FX = 411775;

    typedef logic signed [W_DEF-1:0] fx_t;
    typedef fx_t [JOINTS_DEF-1:0]    fx_vec_t;
    typedef fx_t [ERR_N_DEF-1:0]     err_vec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CHECK,
        S_UPDATE,
        S_DONE
    } state_t;

endpackage

// File: rtl/ik_joint_update.sv
// Combinational single-joint state update.
//   theta_cur  : committed joint value
//   delta      : raw delta from the iteration core
//   step_shift : arithmetic right shift applied to delta (step damping)
//   rotational : 1 = angle (wrapped into [-PI, PI]), 0 = linear
//   lim_lo/hi  : signed joint limits, lim_lo <= lim_hi
//   theta_nxt  : shifted, summed, wrapped and clamped result
module ik_joint_update #(
    parameter int W           = 21,
    parameter int PI_FX_P     = 205887,
    parameter int TWO_PI_FX_P = 411775
) (
    input  logic signed [W-1:0] theta_cur,
    input  logic signed [W-1:0] delta,
    input  logic        [2:0]   step_shift,
    input  logic                rotational,
    input  logic signed [W-1:0] lim_lo,
    input  logic signed [W-1:0] lim_hi,
    output logic signed [W-1:0] theta_nxt
);

    // Two guard bits: one for the sum, one for the wrap correction.
    localparam int TW = W + 2;
    localparam logic signed [TW-1:0] PI_T     = TW'(PI_FX_P);
    localparam logic signed [TW-1:0] TWO_PI_T = TW'(TWO_PI_FX_P);

    logic signed [W-1:0]  step;
    logic signed [TW-1:0] t_sum;
    logic signed [TW-1:0] t_wrap;
    logic signed [TW-1:0] lo_t;
    logic signed [TW-1:0] hi_t;

    always_comb begin
        step  = delta >>> step_shift;
        t_sum = {{2{theta_cur[W-1]}}, theta_cur} + {{2{step[W-1]}}, step};

        // A single correction suffices: |step| and |theta| are both well under 2PI
        // relative to the guard range, so one wrap lands back inside [-PI, PI].
        t_wrap = t_sum;
        if (rotational) begin
            if (t_sum > PI_T) begin
                t_wrap = t_sum - TWO_PI_T;
            end else if (t_sum < -PI_T) begin
                t_wrap = t_sum + TWO_PI_T;
            end
        end

        lo_t = {{2{lim_lo[W-1]}}, lim_lo};
        hi_t = {{2{lim_hi[W-1]}}, lim_hi};
        if (t_wrap < lo_t) begin
            theta_nxt = lim_lo;
        end else if (t_wrap > hi_t) begin
            theta_nxt = lim_hi;
        end else begin
            theta_nxt = t_wrap[W-1:0];
        end
    end

endmodule

// File: rtl/ik_iter_ctrl.sv
// Multi-iteration sequencer for the DLS IK engine.
// Repeatedly enables the single-iteration core, accumulates its scaled joint
// deltas into theta (wrapped and clamped), and stops on convergence (L1 error
// norm <= tol), on reaching the iteration limit, or on abort.
// Ports:
//   clk, rst (async, active low)
//   start, abort                  : run control
//   max_iter, tol, step_shift     : run configuration (max_iter 0 acts as 1)
//   joint_type, dh_init           : joint kinds and initial joint values
//   lim_lo, lim_hi                : per-joint signed limits
//   core_en / core_done           : handshake to the iteration core
//   core_delta, core_err          : core results, valid with core_done
//   theta                         : committed joint state (feeds core dh_dyn_in)
//   busy, done, converged, aborted: run status
//   iter_count, err_norm          : completed iterations, last L1 error norm
module ik_iter_ctrl
    import ik_pkg::*;
#(
    parameter  int JOINTS   = 6,
    parameter  int W        = 21,
    parameter  int FRAC     = 16,
    parameter  int ERR_N    = 6,
    parameter  int MAX_ITER = 255,
    localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ITER_W-1:0]     max_iter,
    input  logic [W+2:0]          tol,
    input  logic [2:0]            step_shift,
    input  logic [JOINTS-1:0]     joint_type,
    input  logic [JOINTS*W-1:0]   dh_init,
    input  logic [JOINTS*W-1:0]   lim_lo,
    input  logic [JOINTS*W-1:0]   lim_hi,
    output logic                  core_en,
    input  logic                  core_done,
    input  logic [JOINTS*W-1:0]   core_delta,
    input  logic [ERR_N*W-1:0]    core_err,
    output logic [JOINTS*W-1:0]   theta,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic                  aborted,
    output logic [ITER_W-1:0]     iter_count,
    output logic [W+2:0]          err_norm
);

    // PI constants rescaled from the 16-bit-fraction reference values.
    localparam int PI_P     = (FRAC >= 16) ? (PI_FX <<< (FRAC - 16))
                                           : (PI_FX >>> (16 - FRAC));
    localparam int TWO_PI_P = (FRAC >= 16) ? (TWO_PI_FX <<< (FRAC - 16))
                                           : (TWO_PI_FX >>> (16 - FRAC));

    state_t state;
    state_t state_nxt;

    logic [JOINTS*W-1:0] delta_q;
    logic [ERR_N*W-1:0]  err_q;
    logic [JOINTS*W-1:0] theta_upd;
    logic [W+2:0]        norm_sum;
    logic signed [W:0]   e_ext;
    logic [W:0]          e_mag;
    logic [ITER_W-1:0]   iter_lim;

    logic do_init;
    logic do_latch;
    logic do_norm;
    logic do_conv;
    logic do_commit;
    logic do_finish;
    logic do_abort;

    assign iter_lim = (max_iter == '0) ? ITER_W'(1) : max_iter;

    // L1 norm; each magnitude taken one bit wider so the most negative word is exact.
    always_comb begin
        norm_sum = '0;
        e_ext    = '0;
        e_mag    = '0;
        for (int k = 0; k < ERR_N; k++) begin
            e_ext    = {err_q[k*W+W-1], err_q[k*W +: W]};
            e_mag    = e_ext[W] ? -e_ext : e_ext;
            norm_sum = norm_sum + {2'b00, e_mag};
        end
    end

    for (genvar j = 0; j < JOINTS; j++) begin : g_joint
        ik_joint_update #(
            .W           (W),
            .PI_FX_P     (PI_P),
            .TWO_PI_FX_P (TWO_PI_P)
        ) u_upd (
            .theta_cur  (theta[j*W +: W]),
            .delta      (delta_q[j*W +: W]),
            .step_shift (step_shift),
            .rotational (joint_type[j]),
            .lim_lo     (lim_lo[j*W +: W]),
            .lim_hi     (lim_hi[j*W +: W]),
            .theta_nxt  (theta_upd[j*W +: W])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort is tested first in every active state so it pre-empts any other move.
    always_comb begin
        state_nxt = state;
        core_en   = 1'b0;
        do_init   = 1'b0;
        do_latch  = 1'b0;
        do_norm   = 1'b0;
        do_conv   = 1'b0;
        do_commit = 1'b0;
        do_finish = 1'b0;
        do_abort  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    do_init   = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    do_abort  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                core_en = 1'b1;
                if (abort) begin
                    do_abort  = 1'b1;
                    state_nxt = S_DONE;
                end else if (core_done) begin
                    do_latch  = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    do_abort  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    do_norm = 1'b1;
                    if (norm_sum <= tol) begin
                        do_conv   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                if (abort) begin
                    do_abort  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    do_commit = 1'b1;
                    if (iter_count >= iter_lim) begin
                        do_finish = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_latch) begin
            delta_q <= core_delta;
            err_q   <= core_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            theta      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            converged  <= 1'b0;
            aborted    <= 1'b0;
            iter_count <= '0;
            err_norm   <= '0;
        end else begin
            if (do_init) begin
                theta      <= dh_init;
                iter_count <= '0;
                err_norm   <= '0;
                done       <= 1'b0;
                converged  <= 1'b0;
                aborted    <= 1'b0;
                busy       <= 1'b1;
            end
            if (do_latch && (iter_count != ITER_W'(MAX_ITER))) begin
                iter_count <= iter_count + 1'b1;
            end
            if (do_norm) begin
                err_norm <= norm_sum;
            end
            if (do_commit) begin
                theta <= theta_upd;
            end
            if (do_conv || do_finish || do_abort) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (do_conv) begin
                converged <= 1'b1;
            end
            if (do_abort) begin
                aborted   <= 1'b1;
                converged <= 1'b0;
            end
        end
    end

endmodule
